// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roll sequencer.
package dice_pkg;

    localparam int VALUE_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SLOW = 2'd2,
        SHOW = 2'd3
    } state_t;

    // Number of faces on the die selected by a select_dice code
    function automatic logic [VALUE_W-1:0] dice_faces(input logic [2:0] code);
        logic [VALUE_W-1:0] faces;
        case (code)
            3'd0:    faces = 7'd4;
            3'd1:    faces = 7'd6;
            3'd2:    faces = 7'd8;
            3'd3:    faces = 7'd10;
            3'd4:    faces = 7'd12;
            3'd5:    faces = 7'd20;
            3'd6:    faces = 7'd100;
            default: faces = 7'd2;
        endcase
        return faces;
    endfunction

endpackage

// File: rtl/dice_step_timer.sv
// Loadable down-counter. tick is high for one cycle while enabled and the
// count has reached zero; the owner reloads on tick to start the next interval.
module dice_step_timer #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == '0);

    // Next count: load wins, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: locks the selected die on a roll press, spins the face
// value, decelerates over doubling intervals, then shows the result with a
// one-cycle done pulse.
// Optional build macro DICE_TOTAL_EN adds a saturating running total of results
// (ports total_clr / total).
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int SPIN_DIV   = 4,
    parameter int MIN_SPIN   = 8,
    parameter int SLOW_STEPS = 5,
    parameter int SLOW_BASE  = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               roll,
    input  logic [2:0]         dice,
`ifdef DICE_TOTAL_EN
    input  logic               total_clr,
    output logic [9:0]         total,
`endif
    output logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic               sel_lock
);

    localparam int SLOW_MAX  = SLOW_BASE << (SLOW_STEPS - 1);
    localparam int TMR_W_IV  = $clog2(SLOW_MAX) + 1;
    localparam int TMR_W_DIV = $clog2(SPIN_DIV) + 1;
    localparam int TMR_W     = (TMR_W_IV > TMR_W_DIV) ? TMR_W_IV : TMR_W_DIV;
    localparam int SPIN_W    = (MIN_SPIN > 0) ? $clog2(MIN_SPIN + 1) : 1;
    localparam int IDX_W     = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;

    state_t               state_q, state_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2:0]           dice_q, dice_d;
    logic                 roll_q;
    logic [SPIN_W-1:0]    spin_cnt_q, spin_cnt_d;
    logic [IDX_W-1:0]     slow_idx_q, slow_idx_d;
    logic                 stepped_q, stepped_d;

    logic [VALUE_W-1:0]   faces;
    logic [VALUE_W-1:0]   face_next;
    logic                 start;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_tick;

    // Faces come from the latched code so a dice change mid-roll has no effect
    assign faces     = dice_faces(dice_q);
    assign face_next = (value_q == faces) ? VALUE_W'(1) : value_q + VALUE_W'(1);
    assign start     = roll && !roll_q;

    // One timer serves as the SPIN divider and as the SLOW interval counter
    dice_step_timer #(
        .W (TMR_W)
    ) u_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (busy_q),
        .tick     (tmr_tick)
    );

    // Next-state logic for the roll sequence
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dice_d     = dice_q;
        spin_cnt_d = spin_cnt_q;
        slow_idx_d = slow_idx_q;
        stepped_d  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = TMR_W'(SPIN_DIV - 1);

        case (state_q)
            IDLE, SHOW: begin
                if (start) begin
                    state_d    = SPIN;
                    dice_d     = dice;
                    value_d    = VALUE_W'(1);
                    spin_cnt_d = '0;
                    busy_d     = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(SPIN_DIV - 1);
                end
            end

            SPIN: begin
                // Exit is only considered on the cycle right after a face step
                if (stepped_q && (spin_cnt_q >= SPIN_W'(MIN_SPIN)) && !roll) begin
                    state_d    = SLOW;
                    slow_idx_d = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(SLOW_BASE - 1);
                end else if (tmr_tick) begin
                    value_d   = face_next;
                    stepped_d = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(SPIN_DIV - 1);
                    if (spin_cnt_q < SPIN_W'(MIN_SPIN)) begin
                        spin_cnt_d = spin_cnt_q + SPIN_W'(1);
                    end
                end
            end

            SLOW: begin
                if (tmr_tick) begin
                    value_d = face_next;
                    if (slow_idx_q == IDX_W'(SLOW_STEPS - 1)) begin
                        state_d = SHOW;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        slow_idx_d = slow_idx_q + IDX_W'(1);
                        tmr_load   = 1'b1;
                        tmr_val    = (TMR_W'(SLOW_BASE) << (slow_idx_q + IDX_W'(1)))
                                     - TMR_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            value_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dice_q     <= '0;
            roll_q     <= 1'b0;
            spin_cnt_q <= '0;
            slow_idx_q <= '0;
            stepped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dice_q     <= dice_d;
            roll_q     <= roll;
            spin_cnt_q <= spin_cnt_d;
            slow_idx_q <= slow_idx_d;
            stepped_q  <= stepped_d;
        end
    end

    assign value    = value_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sel_lock = busy_q;

`ifdef DICE_TOTAL_EN
    logic [9:0]  total_q, total_d;
    logic [10:0] total_sum;

    // Saturating accumulation of each final result; clear has priority
    always_comb begin
        total_sum = {1'b0, total_q} + {4'b0000, value_q};
        total_d   = total_q;
        if (total_clr) begin
            total_d = '0;
        end else if (done_q) begin
            total_d = total_sum[10] ? 10'd1023 : total_sum[9:0];
        end
    end

    // Running total register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total = total_q;
`endif

endmodule
